// File: rtl/kanagawa_quad_port_memory_arbiter.sv
// Round-robin arbiter sharing a 2-write/2-read memory among N_REQ requesters.
// Define KANAGAWA_MEM_ARB_STATS_EN to enable the saturating stall counters.
module kanagawa_quad_port_memory_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_DELAY  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            rd_req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] rd_req_addr,
  output logic [N_REQ-1:0]            rd_req_ready,
  input  logic [N_REQ-1:0]            wr_req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wr_req_data,
  output logic [N_REQ-1:0]            wr_req_ready,
  output logic [N_REQ-1:0]            rd_rsp_valid,
  output logic [N_REQ*DATA_WIDTH-1:0] rd_rsp_data,
  output logic [2*ADDR_WIDTH-1:0]     mem_write_addr,
  output logic [1:0]                  mem_wren,
  output logic [2*DATA_WIDTH-1:0]     mem_data,
  output logic [1:0]                  mem_rden,
  output logic [2*ADDR_WIDTH-1:0]     mem_read_addr,
  input  logic [2*DATA_WIDTH-1:0]     mem_rddata,
  output logic [31:0]                 stat_rd_hazard_stalls,
  output logic [31:0]                 stat_wr_conflict_stalls
);

  localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IW1 = IW + 1;
  localparam int PD  = 1 + READ_LATENCY;

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n
    $error("N_REQ must be in 2..16");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_rl
    $error("READ_LATENCY must be 1 or 2");
  end
  if (WRITE_DELAY < 0) begin : g_bad_wd
    $error("WRITE_DELAY must be >= 0");
  end

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] p,
    input int            k
  );
    logic [IW1-1:0] s;
    s = {1'b0, p} + IW1'(k);
    if (s >= IW1'(N_REQ)) s = s - IW1'(N_REQ);
    return s[IW-1:0];
  endfunction

  logic [IW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] wr_last, rd_last;
  logic [IW-1:0] w_idx, r_idx;
  logic [ADDR_WIDTH-1:0] w_a;

  logic [1:0]                 wg_v, rg_v;
  logic [1:0][ADDR_WIDTH-1:0] wg_a, rg_a;
  logic [1:0][DATA_WIDTH-1:0] wg_d;
  logic [1:0][IW-1:0]         rg_i;

  logic [N_REQ-1:0] wr_gnt, rd_gnt;
  logic [N_REQ-1:0] rd_hit, sb_hit;

  logic [1:0][PD-1:0] tag_v;
  logic [IW-1:0]      tag_i [2][PD];

  // A second write to slot 0's address is skipped so the pair never collides.
  always_comb begin
    wg_v    = '0;
    wg_a    = '0;
    wg_d    = '0;
    wr_gnt  = '0;
    wr_last = wr_ptr;
    w_idx   = '0;
    w_a     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = wrap(wr_ptr, k);
      w_a   = wr_req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
      if (!rst && wr_req_valid[w_idx]) begin
        if (!wg_v[0]) begin
          wg_v[0]       = 1'b1;
          wg_a[0]       = w_a;
          wg_d[0]       = wr_req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
          wr_gnt[w_idx] = 1'b1;
          wr_last       = w_idx;
        end else if (!wg_v[1] && w_a != wg_a[0]) begin
          wg_v[1]       = 1'b1;
          wg_a[1]       = w_a;
          wg_d[1]       = wr_req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
          wr_gnt[w_idx] = 1'b1;
          wr_last       = w_idx;
        end
      end
    end
  end

  if (WRITE_DELAY > 0) begin : g_sb
    logic [1:0]                 sb_v [WRITE_DELAY];
    logic [1:0][ADDR_WIDTH-1:0] sb_a [WRITE_DELAY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int d = 0; d < WRITE_DELAY; d++) begin
          sb_v[d] <= '0;
          sb_a[d] <= '0;
        end
      end else begin
        sb_v[0] <= wg_v;
        sb_a[0] <= wg_a;
        for (int d = 1; d < WRITE_DELAY; d++) begin
          sb_v[d] <= sb_v[d-1];
          sb_a[d] <= sb_a[d-1];
        end
      end
    end

    always_comb begin
      sb_hit = '0;
      for (int i = 0; i < N_REQ; i++)
        for (int d = 0; d < WRITE_DELAY; d++)
          for (int p = 0; p < 2; p++)
            if (sb_v[d][p] &&
                sb_a[d][p] == rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH])
              sb_hit[i] = 1'b1;
    end
  end else begin : g_no_sb
    assign sb_hit = '0;
  end

  always_comb begin
    rd_hit = sb_hit;
    for (int i = 0; i < N_REQ; i++)
      for (int p = 0; p < 2; p++)
        if (wg_v[p] &&
            wg_a[p] == rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH])
          rd_hit[i] = 1'b1;
  end

  always_comb begin
    rg_v    = '0;
    rg_a    = '0;
    rg_i    = '0;
    rd_gnt  = '0;
    rd_last = rd_ptr;
    r_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      r_idx = wrap(rd_ptr, k);
      if (!rst && rd_req_valid[r_idx] && !rd_hit[r_idx] && !rg_v[1]) begin
        if (!rg_v[0]) begin
          rg_v[0] = 1'b1;
          rg_a[0] = rd_req_addr[r_idx*ADDR_WIDTH +: ADDR_WIDTH];
          rg_i[0] = r_idx;
        end else begin
          rg_v[1] = 1'b1;
          rg_a[1] = rd_req_addr[r_idx*ADDR_WIDTH +: ADDR_WIDTH];
          rg_i[1] = r_idx;
        end
        rd_gnt[r_idx] = 1'b1;
        rd_last       = r_idx;
      end
    end
  end

  assign wr_req_ready = wr_gnt;
  assign rd_req_ready = rd_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      mem_wren       <= '0;
      mem_rden       <= '0;
      mem_write_addr <= '0;
      mem_data       <= '0;
      mem_read_addr  <= '0;
      tag_v          <= '0;
      for (int p = 0; p < 2; p++)
        for (int s = 0; s < PD; s++)
          tag_i[p][s] <= '0;
    end else begin
      if (|wg_v) wr_ptr <= wrap(wr_last, 1);
      if (|rg_v) rd_ptr <= wrap(rd_last, 1);
      mem_wren       <= wg_v;
      mem_write_addr <= wg_a;
      mem_data       <= wg_d;
      mem_rden       <= rg_v;
      mem_read_addr  <= rg_a;
      for (int p = 0; p < 2; p++) begin
        tag_v[p]    <= {tag_v[p][PD-2:0], rg_v[p]};
        tag_i[p][0] <= rg_i[p];
        for (int s = 1; s < PD; s++)
          tag_i[p][s] <= tag_i[p][s-1];
      end
    end
  end

  always_comb begin
    rd_rsp_valid = '0;
    rd_rsp_data  = '0;
    for (int p = 0; p < 2; p++)
      if (!rst && tag_v[p][PD-1]) begin
        rd_rsp_valid[tag_i[p][PD-1]] = 1'b1;
        rd_rsp_data[tag_i[p][PD-1]*DATA_WIDTH +: DATA_WIDTH] =
          mem_rddata[p*DATA_WIDTH +: DATA_WIDTH];
      end
  end

`ifdef KANAGAWA_MEM_ARB_STATS_EN
  localparam int CW = $clog2(N_REQ + 1);

  logic [CW-1:0] hz_n, cf_n;
  logic [31:0]   hz_cnt, cf_cnt;

  function automatic logic [31:0] sat_add(
    input logic [31:0]   a,
    input logic [CW-1:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? {32{1'b1}} : s[31:0];
  endfunction

  always_comb begin
    hz_n = '0;
    cf_n = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!rst && rd_req_valid[i] && rd_hit[i])
        hz_n = hz_n + CW'(1);
      if (!rst && wr_req_valid[i] && !wr_gnt[i] && wg_v[0] &&
          wr_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wg_a[0])
        cf_n = cf_n + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hz_cnt <= '0;
      cf_cnt <= '0;
    end else begin
      hz_cnt <= sat_add(hz_cnt, hz_n);
      cf_cnt <= sat_add(cf_cnt, cf_n);
    end
  end

  assign stat_rd_hazard_stalls   = hz_cnt;
  assign stat_wr_conflict_stalls = cf_cnt;
`else
  assign stat_rd_hazard_stalls   = '0;
  assign stat_wr_conflict_stalls = '0;
`endif

endmodule

// File: tb/tb_kanagawa_quad_port_memory_arbiter.sv
// Directed bench for kanagawa_quad_port_memory_arbiter with a
// behavioural quad-port memory (read latency 2, write delay 2).
module tb_kanagawa_quad_port_memory_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int RL = 2;
  localparam int WD = 2;

`ifdef KANAGAWA_MEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]    rd_req_valid = '0;
  logic [N*AW-1:0] rd_req_addr  = '0;
  logic [N-1:0]    rd_req_ready;
  logic [N-1:0]    wr_req_valid = '0;
  logic [N*AW-1:0] wr_req_addr  = '0;
  logic [N*DW-1:0] wr_req_data  = '0;
  logic [N-1:0]    wr_req_ready;
  logic [N-1:0]    rd_rsp_valid;
  logic [N*DW-1:0] rd_rsp_data;
  logic [2*AW-1:0] mem_write_addr;
  logic [1:0]      mem_wren;
  logic [2*DW-1:0] mem_data;
  logic [1:0]      mem_rden;
  logic [2*AW-1:0] mem_read_addr;
  logic [2*DW-1:0] mem_rddata;
  logic [31:0]     stat_rd_hazard_stalls;
  logic [31:0]     stat_wr_conflict_stalls;

  int checks = 0;
  int errors = 0;

  kanagawa_quad_port_memory_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .READ_LATENCY(RL), .WRITE_DELAY(WD)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .rd_req_valid(rd_req_valid),
    .rd_req_addr(rd_req_addr),
    .rd_req_ready(rd_req_ready),
    .wr_req_valid(wr_req_valid),
    .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data),
    .wr_req_ready(wr_req_ready),
    .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_data(rd_rsp_data),
    .mem_write_addr(mem_write_addr),
    .mem_wren(mem_wren),
    .mem_data(mem_data),
    .mem_rden(mem_rden),
    .mem_read_addr(mem_read_addr),
    .mem_rddata(mem_rddata),
    .stat_rd_hazard_stalls(stat_rd_hazard_stalls),
    .stat_wr_conflict_stalls(stat_wr_conflict_stalls)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]   mem  [64] = '{5: 32'hA5, default: 32'h0};
  logic [1:0]      wq_v [WD] = '{default: '0};
  logic [2*AW-1:0] wq_a [WD] = '{default: '0};
  logic [2*DW-1:0] wq_d [WD] = '{default: '0};
  logic [2*DW-1:0] rp   [RL] = '{default: '0};

  // Reads sample the array before this edge's commit lands.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      rp[0][p*DW +: DW] <= mem_rden[p] ?
        mem[mem_read_addr[p*AW +: AW]] : '0;
      if (wq_v[WD-1][p])
        mem[wq_a[WD-1][p*AW +: AW]] <= wq_d[WD-1][p*DW +: DW];
    end
    for (int d = 1; d < RL; d++) rp[d] <= rp[d-1];
    for (int d = 1; d < WD; d++) begin
      wq_v[d] <= wq_v[d-1];
      wq_a[d] <= wq_a[d-1];
      wq_d[d] <= wq_d[d-1];
    end
    wq_v[0] <= mem_wren;
    wq_a[0] <= mem_write_addr;
    wq_d[0] <= mem_data;
  end

  assign mem_rddata = rp[RL-1];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rd_req_valid = '0;
    wr_req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    rd_req_valid = '1;
    wr_req_valid = '1;
    #1;
    checks++;
    if (rd_req_ready !== 4'b0000) begin errors++;
      $display("FAIL rst_rd_ready got %b want 0000", rd_req_ready); end
    checks++;
    if (wr_req_ready !== 4'b0000) begin errors++;
      $display("FAIL rst_wr_ready got %b want 0000", wr_req_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (mem_wren !== 2'b00 || mem_rden !== 2'b00) begin errors++;
      $display("FAIL rst_en got wren=%b rden=%b want 00 00",
               mem_wren, mem_rden); end
    checks++;
    if (mem_write_addr !== '0 || mem_read_addr !== '0 ||
        mem_data !== '0) begin errors++;
      $display("FAIL rst_mem_bus got wa=%h ra=%h d=%h want 0",
               mem_write_addr, mem_read_addr, mem_data); end
    checks++;
    if (rd_rsp_valid !== '0 || rd_rsp_data !== '0) begin errors++;
      $display("FAIL rst_rsp got v=%b d=%h want 0",
               rd_rsp_valid, rd_rsp_data); end
    checks++;
    if (stat_rd_hazard_stalls !== 32'd0 ||
        stat_wr_conflict_stalls !== 32'd0) begin errors++;
      $display("FAIL rst_stats got %0d %0d want 0 0",
               stat_rd_hazard_stalls, stat_wr_conflict_stalls); end
    rd_req_valid = '0;
    wr_req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_rr();
    do_reset();
    for (int i = 0; i < N; i++) begin
      wr_req_addr[i*AW +: AW] = AW'(i);
      wr_req_data[i*DW +: DW] = 32'h100 + i;
    end
    wr_req_valid = 4'b1111;
    #1;
    checks++;
    if (wr_req_ready !== 4'b0011) begin errors++;
      $display("FAIL wr_rr_c0 got %b want 0011", wr_req_ready); end
    @(negedge clk);
    wr_req_valid = 4'b1100;
    #1;
    checks++;
    if (wr_req_ready !== 4'b1100) begin errors++;
      $display("FAIL wr_rr_c1 got %b want 1100", wr_req_ready); end
    checks++;
    if (mem_wren !== 2'b11 || mem_write_addr !== {6'd1, 6'd0} ||
        mem_data !== {32'h101, 32'h100}) begin errors++;
      $display("FAIL wr_rr_cmd0 got en=%b a=%h d=%h want 11 040 101/100",
               mem_wren, mem_write_addr, mem_data); end
    @(negedge clk);
    wr_req_valid = 4'b0111;
    #1;
    checks++;
    if (mem_wren !== 2'b11 || mem_write_addr !== {6'd3, 6'd2} ||
        mem_data !== {32'h103, 32'h102}) begin errors++;
      $display("FAIL wr_rr_cmd1 got en=%b a=%h d=%h want 11 0c2 103/102",
               mem_wren, mem_write_addr, mem_data); end
    checks++;
    if (wr_req_ready !== 4'b0011) begin errors++;
      $display("FAIL wr_ptr_wrap got %b want 0011", wr_req_ready); end
    @(negedge clk);
    wr_req_valid = 4'b0100;
    #1;
    checks++;
    if (wr_req_ready !== 4'b0100) begin errors++;
      $display("FAIL wr_rr_single got %b want 0100", wr_req_ready); end
    @(negedge clk);
    wr_req_valid = '0;
    #1;
    checks++;
    if (mem_wren !== 2'b01 || mem_write_addr[AW-1:0] !== 6'd2) begin
      errors++;
      $display("FAIL wr_rr_port0 got en=%b a=%h want 01 02",
               mem_wren, mem_write_addr); end
    @(negedge clk);
    #1;
    checks++;
    if (mem_wren !== 2'b00) begin errors++;
      $display("FAIL wr_idle got %b want 00", mem_wren); end
  endtask

  task automatic test_read_latency();
    do_reset();
    rd_req_addr[1*AW +: AW] = 6'd5;
    rd_req_valid = 4'b0010;
    #1;
    checks++;
    if (rd_req_ready !== 4'b0010) begin errors++;
      $display("FAIL rdlat_ready got %b want 0010", rd_req_ready); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      rd_req_valid = '0;
      #1;
      if (c == 1) begin
        checks++;
        if (mem_rden !== 2'b01 || mem_read_addr[AW-1:0] !== 6'd5) begin
          errors++;
          $display("FAIL rdlat_cmd got en=%b a=%h want 01 05",
                   mem_rden, mem_read_addr); end
      end
      if (c == 3) begin
        checks++;
        if (rd_rsp_valid !== 4'b0010) begin errors++;
          $display("FAIL rdlat_valid got %b want 0010", rd_rsp_valid); end
        checks++;
        if (rd_rsp_data !== {32'h0, 32'h0, 32'hA5, 32'h0}) begin
          errors++;
          $display("FAIL rdlat_data got %h want A5 in slice 1",
                   rd_rsp_data); end
      end else begin
        checks++;
        if (rd_rsp_valid !== 4'b0000) begin errors++;
          $display("FAIL rdlat_off c%0d got %b want 0000",
                   c, rd_rsp_valid); end
      end
    end
  endtask

  task automatic test_hazard();
    do_reset();
    wr_req_addr[0 +: AW] = 6'd7;
    wr_req_data[0 +: DW] = 32'h11;
    rd_req_addr[2*AW +: AW] = 6'd7;
    wr_req_valid = 4'b0001;
    rd_req_valid = 4'b0100;
    #1;
    checks++;
    if (wr_req_ready !== 4'b0001 || rd_req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL haz_t0 got wr=%b rd=%b want 0001 0000",
               wr_req_ready, rd_req_ready); end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      wr_req_valid = '0;
      if (c >= 4) rd_req_valid = '0;
      #1;
      if (c == 1) begin
        checks++;
        if (mem_wren !== 2'b01 || mem_write_addr[AW-1:0] !== 6'd7 ||
            mem_data[DW-1:0] !== 32'h11) begin errors++;
          $display("FAIL haz_wcmd got en=%b a=%h d=%h want 01 07 11",
                   mem_wren, mem_write_addr, mem_data); end
      end
      if (c < 3) begin
        checks++;
        if (rd_req_ready !== 4'b0000) begin errors++;
          $display("FAIL haz_block c%0d got %b want 0000",
                   c, rd_req_ready); end
      end
      if (c == 3) begin
        checks++;
        if (rd_req_ready !== 4'b0100) begin errors++;
          $display("FAIL haz_accept got %b want 0100", rd_req_ready); end
      end
      if (c == 4) begin
        checks++;
        if (stat_rd_hazard_stalls !== (STATS ? 32'd3 : 32'd0)) begin
          errors++;
          $display("FAIL haz_stat got %0d want %0d",
                   stat_rd_hazard_stalls, STATS ? 3 : 0); end
      end
      if (c == 6) begin
        checks++;
        if (rd_rsp_valid !== 4'b0100 ||
            rd_rsp_data !== {32'h0, 32'h11, 32'h0, 32'h0}) begin
          errors++;
          $display("FAIL haz_rsp got v=%b d=%h want 0100 11 in slice 2",
                   rd_rsp_valid, rd_rsp_data); end
      end
    end
  endtask

  task automatic test_wr_conflict();
    do_reset();
    wr_req_addr[0*AW +: AW] = 6'd9;
    wr_req_data[0*DW +: DW] = 32'hAAAA0000;
    wr_req_addr[1*AW +: AW] = 6'd4;
    wr_req_data[1*DW +: DW] = 32'h44;
    wr_req_addr[3*AW +: AW] = 6'd9;
    wr_req_data[3*DW +: DW] = 32'hBBBB3333;
    wr_req_valid = 4'b1011;
    #1;
    checks++;
    if (wr_req_ready !== 4'b0011) begin errors++;
      $display("FAIL conf_c0 got %b want 0011", wr_req_ready); end
    @(negedge clk);
    wr_req_valid = 4'b1000;
    #1;
    checks++;
    if (wr_req_ready !== 4'b1000) begin errors++;
      $display("FAIL conf_c1 got %b want 1000", wr_req_ready); end
    checks++;
    if (mem_wren !== 2'b11 || mem_write_addr !== {6'd4, 6'd9}) begin
      errors++;
      $display("FAIL conf_cmd0 got en=%b a=%h want 11 109",
               mem_wren, mem_write_addr); end
    @(negedge clk);
    wr_req_valid = '0;
    #1;
    checks++;
    if (mem_wren !== 2'b01 || mem_write_addr[AW-1:0] !== 6'd9 ||
        mem_data[DW-1:0] !== 32'hBBBB3333) begin errors++;
      $display("FAIL conf_cmd1 got en=%b a=%h d=%h want 01 09 BBBB3333",
               mem_wren, mem_write_addr, mem_data); end
    checks++;
    if (stat_wr_conflict_stalls !== (STATS ? 32'd1 : 32'd0)) begin
      errors++;
      $display("FAIL conf_stat got %0d want %0d",
               stat_wr_conflict_stalls, STATS ? 1 : 0); end
    repeat (4) @(negedge clk);
    checks++;
    if (mem[9] !== 32'hBBBB3333 || mem[4] !== 32'h44) begin errors++;
      $display("FAIL conf_final got m9=%h m4=%h want BBBB3333 44",
               mem[9], mem[4]); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] pat [4];
    pat[0] = 4'b0011;
    pat[1] = 4'b1100;
    pat[2] = 4'b0011;
    pat[3] = 4'b0110;
    do_reset();
    for (int i = 0; i < N; i++) begin
      rd_req_addr[i*AW +: AW] = 6'd5;
      wr_req_addr[i*AW +: AW] = 6'h20;
    end
    for (int k = 0; k < 4; k++) begin
      rd_req_valid = pat[k];
      #1;
      checks++;
      if (rd_req_ready !== pat[k]) begin errors++;
        $display("FAIL mid_issue%0d got %b want %b",
                 k, rd_req_ready, pat[k]); end
      if (k == 3) begin
        checks++;
        if (rd_rsp_valid !== 4'b0011 ||
            rd_rsp_data !== {32'h0, 32'h0, 32'hA5, 32'hA5}) begin
          errors++;
          $display("FAIL mid_first_rsp got v=%b d=%h want 0011 A5/A5",
                   rd_rsp_valid, rd_rsp_data); end
      end
      @(negedge clk);
    end
    rst = 1'b1;
    rd_req_valid = '1;
    wr_req_valid = '1;
    #1;
    checks++;
    if (rd_req_ready !== '0 || wr_req_ready !== '0) begin errors++;
      $display("FAIL mid_rst_ready got rd=%b wr=%b want 0000 0000",
               rd_req_ready, wr_req_ready); end
    checks++;
    if (rd_rsp_valid !== '0) begin errors++;
      $display("FAIL mid_rst_rsp got %b want 0000", rd_rsp_valid); end
    @(negedge clk);
    rst = 1'b0;
    wr_req_valid = '0;
    #1;
    checks++;
    if (rd_req_ready !== 4'b0011) begin errors++;
      $display("FAIL mid_resume got %b want 0011", rd_req_ready); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rd_rsp_valid !== '0) begin errors++;
        $display("FAIL mid_dropped c%0d got %b want 0000",
                 c, rd_rsp_valid); end
      @(negedge clk);
      rd_req_valid = '0;
      #1;
    end
    checks++;
    if (rd_rsp_valid !== 4'b0011 ||
        rd_rsp_data !== {32'h0, 32'h0, 32'hA5, 32'hA5}) begin errors++;
      $display("FAIL mid_new_rsp got v=%b d=%h want 0011 A5/A5",
               rd_rsp_valid, rd_rsp_data); end
    checks++;
    if (stat_rd_hazard_stalls !== 32'd0 ||
        stat_wr_conflict_stalls !== 32'd0) begin errors++;
      $display("FAIL mid_stats got %0d %0d want 0 0",
               stat_rd_hazard_stalls, stat_wr_conflict_stalls); end
  endtask

  initial begin
    test_reset();
    test_write_rr();
    test_read_latency();
    test_hazard();
    test_wr_conflict();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kanagawa_quad_port_memory_arbiter.md
Name: kanagawa_quad_port_memory_arbiter

Overview:
- Shares one simple quad-port memory (2 write ports, 2 read ports) among N_REQ requesters.
- Each cycle grants up to 2 reads and 2 writes, round-robin, and drives registered memory commands.
- Stalls reads that would return stale data because of the memory's write delay; stalls same-address write pairs.
- Routes read data back to the issuing requester after a fixed latency.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 6, memory address width
- READ_LATENCY, 1, memory read latency (1 or 2), same on both read ports
- WRITE_DELAY, 0, memory write delay (>=0), same on both write ports

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req_valid  in  N_REQ  read request per requester
- rd_req_addr  in  N_REQ*ADDR_WIDTH  read address, requester i at slice i
- rd_req_ready  out  N_REQ  read accepted this cycle
- wr_req_valid  in  N_REQ  write request
- wr_req_addr  in  N_REQ*ADDR_WIDTH  write address
- wr_req_data  in  N_REQ*DATA_WIDTH  write data
- wr_req_ready  out  N_REQ  write accepted this cycle
- rd_rsp_valid  out  N_REQ  read data valid for requester i
- rd_rsp_data  out  N_REQ*DATA_WIDTH  read data for requester i
- mem_write_addr  out  2*ADDR_WIDTH  to memory write_addr_in
- mem_wren  out  2  to memory wren_in
- mem_data  out  2*DATA_WIDTH  to memory data_in
- mem_rden  out  2  to memory rden_in
- mem_read_addr  out  2*ADDR_WIDTH  to memory read_addr_in
- mem_rddata  in  2*DATA_WIDTH  from memory data_out
- stat_rd_hazard_stalls  out  32  see Optional Feature
- stat_wr_conflict_stalls  out  32  see Optional Feature

Behaviour:
- Handshake: a request is accepted when valid && ready in the same cycle. Ready is combinational from the valids and arbiter state, and may be high only when the corresponding valid is high. Addr and data must be held stable until accepted.
- Write arbitration:
  - Scan requesters from wr_ptr upward, with wrap, for eligible writes; grant the first two.
  - Slot 0 maps to memory port 0, slot 1 to port 1.
  - If the second candidate's addr equals the first's, skip it and continue scanning; count one wr_conflict stall.
  - wr_ptr <= (last granted index + 1) mod N_REQ. Unchanged if nothing is granted.
- Hazard scoreboard:
  - Shift register, WRITE_DELAY entries deep, each holding 2 (valid, addr) pairs from writes accepted in previous cycles.
  - Cleared on rst. Absent when WRITE_DELAY=0.
- Read arbitration:
  - A read is eligible only if its addr matches neither a write accepted this cycle nor any valid scoreboard entry. Each blocked valid read adds one rd_hazard stall.
  - Two-slot round-robin from rd_ptr, same rule as writes.
  - Two reads to the same address are both granted.
- Command register: grants are registered into mem_* outputs (1 cycle). mem_wren and mem_rden are 0 in cycles with no grant.
- Response pipeline:
  - Per read port, a tag pipe (valid, requester index), 1+READ_LATENCY stages deep.
  - When a stage-end tag is valid, assert rd_rsp_valid[tag] with rd_rsp_data slice = mem_rddata[port].
  - Accept-to-response latency is exactly 1+READ_LATENCY cycles.
  - Non-responding rd_rsp_data slices are 0.
- Simultaneous read and write to the same address in one cycle: the write is granted and the read is stalled. The read is granted WRITE_DELAY+1 cycles later, if not otherwise blocked, and returns the new data.
- Reset values: all ready=0, rd_rsp_valid=0, rd_rsp_data=0, mem_wren=0, mem_rden=0, mem addresses and data=0, rd_ptr=wr_ptr=0, scoreboard and tag pipes cleared, stats=0.
- Reset mid-operation: in-flight read responses are dropped (no rd_rsp_valid after rst). Writes already presented to memory may still commit. No request is accepted while rst=1.
- Elaboration assertions: N_REQ in 2..16, READ_LATENCY in {1,2}, WRITE_DELAY>=0.

Optional Feature:
- KANAGAWA_MEM_ARB_STATS_EN defined: stat_rd_hazard_stalls and stat_wr_conflict_stalls are 32-bit saturating counters. They add the number of stalled requests each cycle and are cleared by rst.
- Not defined: both outputs are tied to 0 and the counter logic is absent.

Test Plan:
- N_REQ=4, all 4 requesters write addr 0..3 in the same cycle -> cycle 0 grants req0 and req1, cycle 1 grants req2 and req3. mem_wren=2'b11 one cycle after each grant; wr_ptr returns to 0.
- READ_LATENCY=2: req1 reads addr 5 (holding 0xA5) -> rd_rsp_valid[1]=1 with data 0xA5 exactly 3 cycles after accept; no other rsp_valid bits set.
- WRITE_DELAY=2: req0 writes addr 7=0x11 in cycle t while req2 reads addr 7 from cycle t -> read blocked in t..t+2, accepted at t+3, returns 0x11. With the stats macro defined, stat_rd_hazard_stalls=3.
- req0 and req3 both write addr 9 in the same cycle, with req1 writing addr 4 -> req0 and req1 granted, req3 stalled one cycle, then granted. Final memory addr 9 holds req3's data; with the stats macro, stat_wr_conflict_stalls=1.
- Issue 2 reads per cycle for 4 cycles, then assert rst for 1 cycle during the returns -> no rd_rsp_valid after the rst cycle; all ready=0 during rst; normal grants resume the next cycle starting from req0.
- Same test compiled without KANAGAWA_MEM_ARB_STATS_EN -> both stat outputs remain 0 throughout.
